memshare_alloc_sched: RTL and testbench
=======================================

MEMSHARE_ALLOC_SCHED -- requirements
Module: memshare_alloc_sched

Interface
REQ-001 The block SHALL provide parameter SHARE_GROUP_SIZE, default 5: number of requestors in one share group (GP1+GP2).
REQ-002 The block SHALL provide parameter RQST_ADDR_BITWIDTH, default 2: column-bank address width per requestor.
REQ-003 The block SHALL provide parameter SHARE_COL_CONFIG, default 5'b10101: bit i = 1 means requestor i is a shared column.
REQ-004 The block SHALL provide parameter TRACK_DEPTH, default 4: arrival-pattern FIFO depth.
REQ-005 The block SHALL provide port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL provide port rstn, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL provide port rqst_valid, input, 1 bit: a request pattern is present this cycle. There is no backpressure.
REQ-008 The block SHALL provide port rqst_flag, input, SHARE_GROUP_SIZE bits: bit i = requestor i is active.
REQ-009 The block SHALL provide port rqst_addr, input, SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH bits: requestor i column-bank address in slice i.
REQ-010 The block SHALL provide port out_ready, input, 1 bit: the downstream L1PA stage accepts the current beat.
REQ-011 The block SHALL provide port out_valid, output, 1 bit: an allocation-sequence beat is valid.
REQ-012 The block SHALL provide port out_grant, output, SHARE_GROUP_SIZE bits: requestors granted in this sequence.
REQ-013 The block SHALL provide port out_addr, output, SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH bits: the pattern's addresses, passed through unchanged.
REQ-014 The block SHALL provide port out_seq_idx, output, 1 bit: allocation sequence number (0 or 1).
REQ-015 The block SHALL provide port out_seq_last, output, 1 bit: last sequence of the current pattern.
REQ-016 The block SHALL provide port drc_clr, input, 1 bit: clears all sticky DRC flags.
REQ-017 The block SHALL provide port drc_flag, output, 3 bits: sticky flags [0]=DRC1, [1]=DRC2, [2]=DRC3.

Function
REQ-018 Input FIFO SHALL store {rqst_flag, rqst_addr} on every cycle with rqst_valid=1, TRACK_DEPTH entries, with wrap-around pointers.
- Push while full and no pop in the same cycle: the pattern SHALL be dropped and drc_flag[2] set.
- Push and pop in the same cycle while full: the push SHALL be accepted and no flag set.
REQ-019 Rank of active requestor i SHALL be the count of active requestors j<i with an equal address.
- Rank 0 -> sequence-0 grant.
- Rank 1 -> sequence-1 grant.
- Rank >=2 -> not granted in either sequence; drc_flag[0] set.
REQ-020 If a requestor with SHARE_COL_CONFIG bit 0 is active with rank >=1, it SHALL NOT be granted and drc_flag[1] SHALL be set.
REQ-021 The FSM SHALL have states IDLE, SEQ0 and SEQ1.
- IDLE: if the FIFO is non-empty, pop, register the pattern and both grant vectors, then go to SEQ0.
- Popped pattern with rqst_flag == 0: discard it, emit no beat, stay in IDLE.
REQ-022 SEQ0 SHALL drive out_valid=1, out_grant=grant0 and out_seq_idx=0.
- out_seq_last SHALL be 1 iff grant1 == 0.
- On out_ready: go to SEQ1 if grant1 != 0, else go to IDLE.
REQ-023 SEQ1 SHALL drive out_valid=1, out_grant=grant1, out_seq_idx=1 and out_seq_last=1; on out_ready, go to IDLE.
REQ-024 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-025 Latency: a push into an empty FIFO in IDLE SHALL produce out_valid two cycles later; there are no idle cycles between consecutive patterns beyond the IDLE pop cycle.
REQ-026 DRC flags SHALL stay set until drc_clr=1. If a set event and drc_clr occur in the same cycle, the set SHALL win.
REQ-027 The maximum number of sequences per pattern SHALL be 2 (MAX_ALLOC_SEQ_NUM).

Reset
REQ-028 When rstn=0 at a sys_clk edge, the block SHALL empty the FIFO, set FSM to IDLE, drive out_valid=0, out_grant=0, out_addr=0, out_seq_idx=0, out_seq_last=0 and drc_flag=0.
REQ-029 Reset asserted mid-sequence SHALL abandon the pattern in flight and all FIFO contents; no beat for them SHALL appear after reset.

Verification
REQ-030 The bench SHALL cover: flag=11111, addr={0,2,1,3,0} (i0..i4) -> beat0 grant=01111, last=0; beat1 grant=10000, last=1; drc=000.
REQ-031 The bench SHALL cover: flag=00101, addr i0=1, i2=3 -> single beat grant=00101, seq_idx=0, last=1.
REQ-032 The bench SHALL cover: flag=00011, both addr=2 (i1 non-shared) -> single beat grant=00001, last=1; drc_flag=010.
REQ-033 The bench SHALL cover: i0, i2, i4 active, all addr=0 -> beat0 grant=00001, beat1 grant=00100; drc_flag=001.
REQ-034 The bench SHALL cover: out_ready=0, then 6 back-to-back pushes -> 4 patterns retained plus 1 in flight, 1 dropped; drc_flag=100; outputs stable while stalled.
REQ-035 The bench SHALL cover: rstn=0 during SEQ1 of a two-beat pattern -> next cycle out_valid=0, drc_flag=000, FIFO empty.

Source files
------------

// File: rtl/memshare_alloc_sched.sv
// Share-group allocation scheduler: queues request patterns, splits each into
// at most two conflict-free grant sequences and flags rule violations.
module memshare_alloc_sched #(
    parameter int                          SHARE_GROUP_SIZE   = 5,
    parameter int                          RQST_ADDR_BITWIDTH = 2,
    parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG   = 5'b10101,
    parameter int                          TRACK_DEPTH        = 4
) (
    input  logic                                         sys_clk,
    input  logic                                         rstn,
    input  logic                                         rqst_valid,
    input  logic [SHARE_GROUP_SIZE-1:0]                  rqst_flag,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
    input  logic                                         out_ready,
    output logic                                         out_valid,
    output logic [SHARE_GROUP_SIZE-1:0]                  out_grant,
    output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] out_addr,
    output logic                                         out_seq_idx,
    output logic                                         out_seq_last,
    input  logic                                         drc_clr,
    output logic [2:0]                                   drc_flag
);
    localparam int N      = SHARE_GROUP_SIZE;
    localparam int AW     = RQST_ADDR_BITWIDTH;
    localparam int PAT_W  = N + N * AW;
    localparam int PTR_W  = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TRACK_DEPTH + 1);
    localparam int RANK_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SEQ0, SEQ1} state_e;

    logic [PAT_W-1:0] mem_q [TRACK_DEPTH];
    logic [PAT_W-1:0] mem_d [TRACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic [N-1:0]     grant0_q, grant0_d, grant1_q, grant1_d;
    logic [N*AW-1:0]  addr_q, addr_d;
    logic [2:0]       drc_q, drc_d;

    logic             full, empty, pop, push_ok, drop_evt;
    logic [N-1:0]     pat_flag, g0, g1;
    logic [N*AW-1:0]  pat_addr;
    logic [RANK_W-1:0] rank;
    logic             drc_rank, drc_share;
    logic [1:0]       drc_set_fsm;

    assign full  = (count_q == CNT_W'(TRACK_DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO still accepts a push when the scheduler pops in the same cycle.
    always_comb begin
        push_ok  = rqst_valid && (!full || pop);
        drop_evt = rqst_valid && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {rqst_flag, rqst_addr};
            wr_ptr_d = (wr_ptr_q == PTR_W'(TRACK_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(TRACK_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop)
            count_d = count_q - CNT_W'(1);
    end

    // Rank = number of lower-index active requestors hitting the same bank.
    always_comb begin
        {pat_flag, pat_addr} = mem_q[rd_ptr_q];
        g0        = '0;
        g1        = '0;
        rank      = '0;
        drc_rank  = 1'b0;
        drc_share = 1'b0;
        for (int i = 0; i < N; i++) begin
            rank = '0;
            for (int j = 0; j < i; j++)
                if (pat_flag[j] && (pat_addr[j*AW +: AW] == pat_addr[i*AW +: AW]))
                    rank = rank + RANK_W'(1);
            if (pat_flag[i]) begin
                if (rank == '0)
                    g0[i] = 1'b1;
                else if (!SHARE_COL_CONFIG[i])
                    drc_share = 1'b1;
                else if (rank == RANK_W'(1))
                    g1[i] = 1'b1;
                if (rank >= RANK_W'(2))
                    drc_rank = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant0_d    = grant0_q;
        grant1_d    = grant1_q;
        addr_d      = addr_q;
        pop         = 1'b0;
        drc_set_fsm = '0;
        case (state_q)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (pat_flag != '0) begin
                    grant0_d    = g0;
                    grant1_d    = g1;
                    addr_d      = pat_addr;
                    drc_set_fsm = {drc_share, drc_rank};
                    state_d     = SEQ0;
                end
            end
            SEQ0:    if (out_ready) state_d = (grant1_q != '0) ? SEQ1 : IDLE;
            SEQ1:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set wins over clear.
    always_comb begin
        drc_d = drc_clr ? 3'b000 : drc_q;
        drc_d = drc_d | {drop_evt, drc_set_fsm};
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            grant0_q <= '0;
            grant1_q <= '0;
            addr_q   <= '0;
            drc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            addr_q   <= addr_d;
            drc_q    <= drc_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    assign out_valid    = (state_q != IDLE);
    assign out_grant    = (state_q == SEQ0) ? grant0_q : (state_q == SEQ1) ? grant1_q : '0;
    assign out_addr     = out_valid ? addr_q : '0;
    assign out_seq_idx  = (state_q == SEQ1);
    assign out_seq_last = ((state_q == SEQ0) && (grant1_q == '0)) || (state_q == SEQ1);
    assign drc_flag     = drc_q;
endmodule

// File: tb/tb_memshare_alloc_sched.sv
// Directed bench for memshare_alloc_sched: vector table plus stall, drop,
// DRC set/clear race and mid-sequence reset sequences.
module tb_memshare_alloc_sched;
    localparam int N  = 5;
    localparam int AW = 2;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic          rqst_valid;
    logic [N-1:0]  rqst_flag;
    logic [N*AW-1:0] rqst_addr;
    logic          out_ready;
    logic          out_valid;
    logic [N-1:0]  out_grant;
    logic [N*AW-1:0] out_addr;
    logic          out_seq_idx;
    logic          out_seq_last;
    logic          drc_clr;
    logic [2:0]    drc_flag;

    int checks = 0;
    int errors = 0;

    memshare_alloc_sched dut (
        .sys_clk(sys_clk), .rstn(rstn), .rqst_valid(rqst_valid), .rqst_flag(rqst_flag),
        .rqst_addr(rqst_addr), .out_ready(out_ready), .out_valid(out_valid),
        .out_grant(out_grant), .out_addr(out_addr), .out_seq_idx(out_seq_idx),
        .out_seq_last(out_seq_last), .drc_clr(drc_clr), .drc_flag(drc_flag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [N-1:0]    flag;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    g0;
        logic            last0;
        logic [N-1:0]    g1;
        logic [2:0]      drc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] f, input logic [N*AW-1:0] a);
        rqst_valid = 1'b1;
        rqst_flag  = f;
        rqst_addr  = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*AW-1:0] got [8];
        int nbeats;

        //            flag      addr {i4..i0}       g0        last0 g1        drc
        vecs[0] = '{5'b11111, 10'b00_11_01_10_00, 5'b01111, 1'b0, 5'b10000, 3'b000};
        vecs[1] = '{5'b00101, 10'b00_00_11_00_01, 5'b00101, 1'b1, 5'b00000, 3'b000};
        vecs[2] = '{5'b00011, 10'b00_00_00_10_10, 5'b00001, 1'b1, 5'b00000, 3'b010};
        vecs[3] = '{5'b10101, 10'b00_00_00_00_00, 5'b00001, 1'b0, 5'b00100, 3'b001};
        vecs[4] = '{5'b11111, 10'b11_11_11_11_11, 5'b00001, 1'b1, 5'b00000, 3'b011};
        vecs[5] = '{5'b01010, 10'b00_01_00_01_00, 5'b00010, 1'b1, 5'b00000, 3'b010};
        vecs[6] = '{5'b11000, 10'b10_10_00_00_00, 5'b01000, 1'b0, 5'b10000, 3'b000};

        rstn = 1'b0; rqst_valid = 1'b0; rqst_flag = '0; rqst_addr = '0;
        out_ready = 1'b1; drc_clr = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_grant", 32'(out_grant), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_idx", 32'(out_seq_idx), 0);
        chk("rst_last", 32'(out_seq_last), 0);
        chk("rst_drc", 32'(drc_flag), 0);
        rstn = 1'b1;
        @(negedge sys_clk);

        // All-inactive pattern is consumed silently.
        push(5'b00000, 10'd5);
        @(negedge sys_clk);
        rqst_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("zero_flag_no_beat", 32'(out_valid), 0);
            @(negedge sys_clk);
        end

        for (int v = 0; v < 7; v++) begin
            drc_clr = 1'b1;
            @(negedge sys_clk);
            drc_clr = 1'b0;
            push(vecs[v].flag, vecs[v].addr);
            @(negedge sys_clk);
            rqst_valid = 1'b0;
            chk($sformatf("v%0d_latency", v), 32'(out_valid), 0);
            @(negedge sys_clk);
            chk($sformatf("v%0d_b0_valid", v), 32'(out_valid), 1);
            chk($sformatf("v%0d_b0_grant", v), 32'(out_grant), 32'(vecs[v].g0));
            chk($sformatf("v%0d_b0_idx", v), 32'(out_seq_idx), 0);
            chk($sformatf("v%0d_b0_last", v), 32'(out_seq_last), 32'(vecs[v].last0));
            chk($sformatf("v%0d_b0_addr", v), 32'(out_addr), 32'(vecs[v].addr));
            @(negedge sys_clk);
            if (vecs[v].g1 != '0) begin
                chk($sformatf("v%0d_b1_valid", v), 32'(out_valid), 1);
                chk($sformatf("v%0d_b1_grant", v), 32'(out_grant), 32'(vecs[v].g1));
                chk($sformatf("v%0d_b1_idx", v), 32'(out_seq_idx), 1);
                chk($sformatf("v%0d_b1_last", v), 32'(out_seq_last), 1);
                chk($sformatf("v%0d_b1_addr", v), 32'(out_addr), 32'(vecs[v].addr));
                @(negedge sys_clk);
            end
            chk($sformatf("v%0d_done", v), 32'(out_valid), 0);
            chk($sformatf("v%0d_drc", v), 32'(drc_flag), 32'(vecs[v].drc));
        end

        // DRC set and clear in the same cycle: set wins, later clear works.
        drc_clr = 1'b1;
        @(negedge sys_clk);
        drc_clr = 1'b0;
        push(vecs[2].flag, vecs[2].addr);
        @(negedge sys_clk);
        rqst_valid = 1'b0;
        drc_clr = 1'b1;
        @(negedge sys_clk);
        drc_clr = 1'b0;
        chk("race_set_wins", 32'(drc_flag), 32'b010);
        @(negedge sys_clk);
        drc_clr = 1'b1;
        @(negedge sys_clk);
        drc_clr = 1'b0;
        chk("race_clear", 32'(drc_flag), 0);

        // Stall: six back-to-back pushes, one in flight, four queued, one dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push(5'b00001, (N*AW)'(k));
            @(negedge sys_clk);
            if (k >= 2) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_grant", 32'(out_grant), 1);
                chk("stall_addr", 32'(out_addr), 1);
                chk("stall_last", 32'(out_seq_last), 1);
            end
        end
        rqst_valid = 1'b0;
        chk("stall_drop_drc", 32'(drc_flag), 32'b100);
        nbeats = 0;
        out_ready = 1'b1;
        drc_clr = 1'b1;
        if (out_valid) begin got[nbeats] = out_addr; nbeats++; end
        @(negedge sys_clk);
        drc_clr = 1'b0;
        chk("drain_idle_gap", 32'(out_valid), 0);
        // FIFO is full here and IDLE pops this cycle: push must be accepted.
        push(5'b00001, (N*AW)'(7));
        @(negedge sys_clk);
        rqst_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && out_ready && nbeats < 8) begin
                got[nbeats] = out_addr;
                nbeats++;
            end
            @(negedge sys_clk);
        end
        chk("drain_count", 32'(nbeats), 6);
        for (int k = 0; k < 5; k++)
            if (k < nbeats) chk($sformatf("drain_order%0d", k), 32'(got[k]), 32'(k + 1));
        if (nbeats >= 6) chk("drain_full_pushpop", 32'(got[5]), 7);
        chk("drain_drc", 32'(drc_flag), 0);

        // Reset during SEQ1 abandons the in-flight pattern and queued work.
        push(vecs[2].flag, vecs[2].addr);
        @(negedge sys_clk);
        push(vecs[0].flag, vecs[0].addr);
        @(negedge sys_clk);
        push(vecs[3].flag, vecs[3].addr);
        @(negedge sys_clk);
        rqst_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("pre_rst_idx", 32'(out_seq_idx), 1);
        chk("pre_rst_grant", 32'(out_grant), 32'b10000);
        chk("pre_rst_drc", 32'(drc_flag), 32'b010);
        rstn = 1'b0;
        out_ready = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_grant", 32'(out_grant), 0);
        chk("mid_rst_addr", 32'(out_addr), 0);
        chk("mid_rst_last", 32'(out_seq_last), 0);
        chk("mid_rst_drc", 32'(drc_flag), 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            chk("post_rst_empty", 32'(out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
